// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode,
// execute and writeback. The per-state controls are registered together
// with the state. ALUControl, ImmSrc and PCWrite are decoded combinationally.
module multicycle_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic [2:0] ALUControl,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       PCWrite,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef struct packed {
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       adr_src;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       pc_update;
      logic       branch;
   } ctrl_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl_q;

   // Control word for a given state; unlisted fields and unused codes stay 0.
   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.ir_write = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1; end
         S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
         S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
         S_MEMREAD:  c.adr_src = 1'b1;
         S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
         S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
         S_EXECUTER: begin c.src_a = 2'b10; c.alu_op = 2'b10; end
         S_EXECUTEI: begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
         S_ALUWB:    c.reg_write = 1'b1;
         S_BEQ:      begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
         S_JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1'b1; end
         default:    c = '0;
      endcase
      return c;
   endfunction

   // Next-state selection from the current state and the held opcode.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // State and its registered Moore controls; reset forces FETCH immediately.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= ctrl_of(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_of(state_d);
      end
   end

   // ALU operation from ALUOp, with funct3/funct7b5 refining the execute step.
   always_comb begin
      ALUControl = 3'b000;
      case (ctrl_q.alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   // Immediate format depends only on the opcode.
   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_STORE:  ImmSrc = 2'b01;
         OP_BRANCH: ImmSrc = 2'b10;
         OP_JAL:    ImmSrc = 2'b11;
         default:   ImmSrc = 2'b00;
      endcase
   end

   assign ALUSrcA   = ctrl_q.src_a;
   assign ALUSrcB   = ctrl_q.src_b;
   assign ResultSrc = ctrl_q.result_src;
   assign AdrSrc    = ctrl_q.adr_src;
   assign IRWrite   = ctrl_q.ir_write;
   assign MemWrite  = ctrl_q.mem_write;
   assign RegWrite  = ctrl_q.reg_write;
   assign PCWrite   = ctrl_q.pc_update | (ctrl_q.branch & Zero);
   assign state     = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports in this order:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- op  input  7  instruction opcode, taken from the instruction register
- funct3  input  3  instruction funct3
- funct7b5  input  1  instruction bit 30
- Zero  input  1  ALU zero flag
- ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  output  2  00 rs2, 01 imm, 10 constant 4
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- AdrSrc  output  1  memory address: 0 PC, 1 Result
- IRWrite, MemWrite, RegWrite, PCWrite  output  1 each  write enables
- state  output  4  current FSM state, for debug and verification

Function
REQ-002 The block SHALL be a Moore FSM with these state codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10.
REQ-003 The FSM SHALL take these transitions:
- FETCH -> DECODE
- DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> FETCH (executed as a NOP)
REQ-004 The FSM SHALL take these further transitions:
- MEMADR: op 0000011 -> MEMREAD; otherwise -> MEMWRITE
- MEMREAD -> MEMWB -> FETCH
- MEMWRITE -> FETCH
- EXECUTER and EXECUTEI -> ALUWB -> FETCH
- BEQ -> FETCH
- JAL -> ALUWB
REQ-005 Unused state codes 11-15 SHALL go to FETCH on the next edge, with all write enables 0 while in them.
REQ-006 Per-state outputs SHALL be as below; any field not listed is 0:
- FETCH: IRWrite=1, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1
- DECODE: SrcA=01, SrcB=01, ALUOp=00
- MEMADR: SrcA=10, SrcB=01, ALUOp=00
- MEMREAD: ResultSrc=00, AdrSrc=1
- MEMWB: ResultSrc=01, RegWrite=1
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1
REQ-007 The remaining per-state outputs SHALL be as below; any field not listed is 0:
- EXECUTER: SrcA=10, SrcB=00, ALUOp=10
- EXECUTEI: SrcA=10, SrcB=01, ALUOp=10
- ALUWB: ResultSrc=00, RegWrite=1
- BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1
- JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1
REQ-008 PCWrite SHALL equal PCUpdate | (Branch & Zero), combinationally in the same cycle.
REQ-009 ALUControl SHALL be decoded from the internal 2-bit ALUOp:
- ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub)
- ALUOp 10, by funct3: 000 -> 001 if op[5]&funct7b5, else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000
- ALUOp 11 -> 000
REQ-010 ImmSrc SHALL be combinational from op alone, independent of state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, any other op -> 00.
REQ-011 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, unsupported op 2.
REQ-012 The decoder inputs (op, funct3, funct7b5) SHALL be held stable by the instruction register from DECODE onward; the block SHALL NOT register them.

Reset
REQ-013 While rst=1, state SHALL be FETCH asynchronously, regardless of clk.
REQ-014 While reset is asserted, outputs SHALL be the FETCH values: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, ALUControl=000, and all other outputs 0 except ImmSrc.
REQ-015 Reset asserted in any state mid-instruction SHALL abort the instruction: no MemWrite or RegWrite pulse SHALL occur after rst rises.
REQ-016 After rst is released, the first rising edge SHALL move the FSM to DECODE.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- lw (op=0000011) from reset -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; ResultSrc=01 in state 4.
- sw (op=0100011) -> states 0,1,2,5,0; MemWrite=1 exactly one cycle; AdrSrc=1 in state 5; ImmSrc=01 throughout.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; the same instruction with funct7b5=0 -> 000. I-type with funct7b5=1 -> 000.
- beq (op=1100011) with Zero=1 -> PCWrite=1 in state 9; with Zero=0 -> PCWrite=0 in state 9. ALUControl=001 in both cases.
- jal (op=1101111) -> states 0,1,10,8,0; PCWrite=1 in state 10; ImmSrc=11.
- op=1111111 -> DECODE returns to FETCH after 2 cycles with no write enables. rst pulsed mid-MEMWRITE -> state=0 immediately and MemWrite=0.
